div_issue_ctrl: RTL

Sequencer between the execute stage and the iterative Division_BLOCK. Accepts one M-extension divide/remainder request at a time and resolves RISC-V special cases (divide-by-zero, signed overflow) without using the divider. Otherwise it launches the divider, holds its operands and opcode stable until completion, buffers the result with its destination tag until the writeback stage accepts it, and drops in-flight work on a pipeline flush.

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_special_case.sv | 33 +++
 rtl/div_issue_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared opcodes, FSM encoding and operand limits for the divide issue path
package div_pkg;

  localparam int DIV_XLEN = 32;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [DIV_XLEN-1:0] INT_MIN  = {1'b1, {(DIV_XLEN-1){1'b0}}};
  localparam logic [DIV_XLEN-1:0] ALL_ONES = '1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESP   = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_special_case.sv
// rtl/div_special_case.sv - resolves divide-by-zero and signed overflow without the divider
module div_special_case
  import div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            is_special_o,
  output logic [XLEN-1:0] special_result_o
);

  localparam logic [XLEN-1:0] MIN_V  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES_V = '1;

  logic div_by_zero;
  logic overflow;

  // op[0] selects unsigned, op[1] selects remainder
  always_comb begin
    div_by_zero      = (rs2_i == '0);
    overflow         = !op_i[0] && (rs1_i == MIN_V) && (rs2_i == ONES_V);
    is_special_o     = div_by_zero || overflow;
    special_result_o = '0;
    if (div_by_zero) begin
      special_result_o = op_i[1] ? rs1_i : ONES_V;
    end else if (overflow) begin
      special_result_o = op_i[1] ? '0 : rs1_i;
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - single-outstanding sequencer between execute and the iterative divider
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [TAG_W-1:0] req_rd,
  output logic             div_valid_o,
  output logic [XLEN-1:0]  div_dividend_o,
  output logic [XLEN-1:0]  div_divisor_o,
  output logic [1:0]       div_op_o,
  input  logic [XLEN-1:0]  div_result_i,
  input  logic             div_ready_i,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_rd,
  output logic             busy
);

  div_state_e       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [XLEN-1:0]  rs1_q, rs1_d;
  logic [XLEN-1:0]  rs2_q, rs2_d;
  logic [TAG_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]  res_q, res_d;

  logic             is_special;
  logic [XLEN-1:0]  special_result;

  div_special_case #(.XLEN(XLEN)) u_special (
    .op_i             (req_op),
    .rs1_i            (req_rs1),
    .rs2_i            (req_rs2),
    .is_special_o     (is_special),
    .special_result_o (special_result)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    res_d   = res_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && !flush) begin
          op_d  = req_op;
          rs1_d = req_rs1;
          rs2_d = req_rs2;
          rd_d  = req_rd;
          if (is_special) begin
            res_d   = special_result;
            state_d = ST_RESP;
          end else begin
            state_d = ST_LAUNCH;
          end
        end
      end
      // The start pulse still goes out on flush; the divider must be drained afterwards
      ST_LAUNCH: state_d = flush ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        if (div_ready_i) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            res_d   = div_result_i;
            state_d = ST_RESP;
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (div_ready_i) state_d = ST_IDLE;
      ST_RESP:  if (flush || resp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
    end
  end

  // Operands and opcode stay registered through WAIT since the divider muxes on op combinationally
  assign req_ready      = (state_q == ST_IDLE) && !flush;
  assign div_valid_o    = (state_q == ST_LAUNCH);
  assign div_dividend_o = rs1_q;
  assign div_divisor_o  = rs2_q;
  assign div_op_o       = op_q;
  assign resp_valid     = (state_q == ST_RESP);
  assign resp_data      = res_q;
  assign resp_rd        = rd_q;
  assign busy           = (state_q != ST_IDLE);

endmodule
